dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have parameter LINES, default 16, giving the number of direct-mapped lines (power of two, 4..256).
REQ-002 The block SHALL have parameter WORDS, default 4, giving the 32-bit words per line (fixed at 4 in this revision).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 addr  in  32  ME-stage byte address (ans_me); bits [1:0] are ignored.
REQ-006 rmem  in  1  ME-stage load request.
REQ-007 wmem  in  1  ME-stage store request.
REQ-008 wdata  in  32  store data (b_me).
REQ-009 rdata  out  32  load data to the WB register (mo_me).
REQ-010 stall  out  1  freezes EX/ME/WB registers and the front end (stall_me).
REQ-011 mem_req  out  1  backing-memory request, held until mem_ack.
REQ-012 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-013 mem_addr  out  32  word-aligned backing-memory address; bits [1:0]=0.
REQ-014 mem_wdata  out  32  backing-memory write data.
REQ-015 mem_rdata  in  32  backing-memory read data; valid in the mem_ack cycle.
REQ-016 mem_ack  in  1  one-cycle completion pulse; may arrive 1..N cycles after mem_req rises.

Function
REQ-017 Address split SHALL be: offset=addr[3:2], index=addr[3+log2(LINES):4], tag=remaining upper bits; a hit SHALL be valid[index] && tag_mem[index]==tag.
REQ-018 The FSM SHALL have exactly the states IDLE, REFILL, WRITE and WDONE.
REQ-019 In IDLE, a read hit (rmem=1, wmem=0) SHALL drive rdata=data[index][offset] combinationally, with stall=0 and zero added latency.
REQ-020 In IDLE, a read miss SHALL assert stall in the same cycle and transition to REFILL with a 2-bit word counter of 0.
REQ-021 In REFILL, the block SHALL hold mem_req=1 and mem_we=0 with mem_addr={tag,index,cnt,2'b00}.
REQ-022 On each mem_ack in REFILL, the block SHALL write mem_rdata into data[index][cnt] and increment cnt.
REQ-023 On the 4th ack in REFILL, the block SHALL set tag_mem[index]=tag and valid[index]=1 and return to IDLE; the replayed access then hits.
REQ-024 A line SHALL never be marked valid with partial data.
REQ-025 stall SHALL be 1 throughout REFILL.
REQ-026 In IDLE, wmem=1 SHALL assert stall and transition to WRITE; this applies whether rmem is 0 or 1 (a write takes priority).
REQ-027 In WRITE, the block SHALL hold mem_req=1, mem_we=1, mem_addr={addr[31:2],2'b00} and mem_wdata=wdata, with stall=1.
REQ-028 On mem_ack in WRITE, the block SHALL update data[index][offset] if the line hits, and go to WDONE.
REQ-029 Writes SHALL be write-through and no-write-allocate: a write miss SHALL leave cache contents unchanged.
REQ-030 WDONE SHALL last one cycle with stall=0 and mem_req=0 so the pipeline advances past the store, then return to IDLE unconditionally.
REQ-031 mem_req SHALL be 0 in IDLE and WDONE; between mem_ack and the next request, mem_req SHALL deassert for at least one cycle.
REQ-032 rdata SHALL be 0 when rmem=0 or stall=1.
REQ-033 addr, rmem, wmem and wdata SHALL be stable while stall=1; the block samples them in each cycle and SHALL NOT register them.

Reset
REQ-034 When reset=0 at a clock edge, the block SHALL set state=IDLE, cnt=0 and all valid bits=0; data and tag arrays need no reset.
REQ-035 While reset=0, the outputs SHALL be stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 and rdata=0.
REQ-036 Reset during REFILL or WRITE SHALL abort the transaction without validating the line; mem_req SHALL be 0 from the cycle after the reset edge.

Structure
REQ-037 A shared package SHALL hold the state encoding (IDLE=2'd0, REFILL=2'd1, WRITE=2'd2, WDONE=2'd3), the WORDS constant and the address-field width functions.
REQ-038 The storage arrays (valid, tag and data) SHALL be one sub-module, dcache_array, with a combinational read port and a synchronous write port.
REQ-039 The FSM, counter and hit logic SHALL reside in dcache_ctrl.

Verification
REQ-040 Cold read: reset, then rmem at addr 0x0000_0104 with the memory returning 0xA0..0xA3 -> stall=1 for 4 acks plus 1 cycle, mem_addr 0x100,0x104,0x108,0x10C, then rdata=0xA1 with stall=0.
REQ-041 Hit: after REQ-040, rmem at 0x108 -> rdata=0xA2 in the same cycle, stall=0, mem_req=0.
REQ-042 Store hit: wmem at 0x10C with wdata=0xDEAD_BEEF and ack after 3 cycles -> mem_we=1 and mem_addr=0x10C; stall=1 until the ack, WDONE gives stall=0, and a following read of 0x10C returns 0xDEAD_BEEF with no refill.
REQ-043 Store miss: wmem at 0x2000 -> one memory write; a following read of 0x2000 misses and refills.
REQ-044 Conflict: with LINES=16, read 0x104 and then read 0x504 (same index) -> the second read refills and evicts, and re-reading 0x104 misses again.
REQ-045 Reset mid-refill: assert reset after the 2nd ack -> mem_req=0 the next cycle, and re-reading the same address performs a full 4-word refill.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared state encoding, line geometry and address-field width helpers for the
// direct-mapped, write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    WDONE  = 2'd3
  } state_e;

  localparam int WORDS    = 4;
  localparam int OFFSET_W = 2;
  localparam int LINE_LSB = OFFSET_W + 2;

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return 32 - LINE_LSB - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid, tag and data storage for the cache: combinational read of one line,
// synchronous single-word and line-metadata write ports.
module dcache_array #(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int IDX_W = dcache_pkg::index_w(LINES),
  parameter int TAG_W = dcache_pkg::tag_w(LINES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [IDX_W-1:0]       rd_index,
  output logic                   rd_valid,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [WORDS-1:0][31:0] rd_line,
  input  logic                   word_we,
  input  logic [IDX_W-1:0]       word_index,
  input  logic [1:0]             word_sel,
  input  logic [31:0]            word_wdata,
  input  logic                   line_we,
  input  logic [IDX_W-1:0]       line_index,
  input  logic                   line_valid,
  input  logic [TAG_W-1:0]       line_tag
);

  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [TAG_W-1:0]       tag_d  [LINES];
  logic [WORDS-1:0][31:0] data_q [LINES];
  logic [WORDS-1:0][31:0] data_d [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (word_we) begin
      data_d[word_index][word_sel] = word_wdata;
    end
    if (line_we) begin
      valid_d[line_index] = line_valid;
      tag_d[line_index]   = line_tag;
    end
  end

  // Only the valid bits need clearing; tag and data contents are don't-care until validated.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through / no-write-allocate data cache controller sitting
// in the ME stage: hit detection, refill/write FSM and backing-memory handshake.
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rmem,
  input  logic        wmem,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  import dcache_pkg::*;

  localparam int IDX_W = index_w(LINES);
  localparam int TAG_W = tag_w(LINES);

  state_e                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   mem_req_q, mem_req_d;

  logic [1:0]             offset;
  logic [IDX_W-1:0]       index;
  logic [TAG_W-1:0]       tag;
  logic                   hit;
  logic                   ack;
  logic                   unused_addr;

  logic                   rd_valid;
  logic [TAG_W-1:0]       rd_tag;
  logic [WORDS-1:0][31:0] rd_line;
  logic                   word_we;
  logic [1:0]             word_sel;
  logic [31:0]            word_wdata;
  logic                   line_we;
  logic                   line_valid;

  assign offset      = addr[3:2];
  assign index       = addr[LINE_LSB +: IDX_W];
  assign tag         = addr[31 -: TAG_W];
  assign unused_addr = ^addr[1:0];
  assign hit         = rd_valid && (rd_tag == tag);
  assign ack         = mem_ack && mem_req_q;

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clock      (clock),
    .reset      (reset),
    .rd_index   (index),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .word_we    (word_we && reset),
    .word_index (index),
    .word_sel   (word_sel),
    .word_wdata (word_wdata),
    .line_we    (line_we && reset),
    .line_index (index),
    .line_valid (line_valid),
    .line_tag   (tag)
  );

  // A miss invalidates the line up front so a half-filled line can never hit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_we    = 1'b0;
    word_sel   = cnt_q;
    word_wdata = mem_rdata;
    line_we    = 1'b0;
    line_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (wmem) begin
          state_d = WRITE;
        end else if (rmem && !hit) begin
          state_d = REFILL;
          cnt_d   = 2'd0;
          line_we = 1'b1;
        end
      end
      REFILL: begin
        if (ack) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d    = IDLE;
            line_we    = 1'b1;
            line_valid = 1'b1;
          end
        end
      end
      WRITE: begin
        if (ack) begin
          state_d    = WDONE;
          word_we    = hit;
          word_sel   = offset;
          word_wdata = wdata;
        end
      end
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Dropping the request for the cycle after every ack gives the memory a clean gap.
    mem_req_d = ((state_d == REFILL) && !ack) || (state_d == WRITE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
    end
  end

  always_comb begin
    stall     = 1'b0;
    rdata     = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          stall = wmem || (rmem && !hit);
          if (rmem && !wmem && hit) begin
            rdata = rd_line[offset];
          end
        end
        REFILL: begin
          stall    = 1'b1;
          mem_addr = {addr[31:4], cnt_q, 2'b00};
        end
        WRITE: begin
          stall     = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {addr[31:2], 2'b00};
          mem_wdata = wdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_req = mem_req_q && reset;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized scoreboard bench for dcache_ctrl: a line-residency model plus a
// word-addressed memory image predict every load result and memory transaction.
module tb_dcache_ctrl;

  localparam int LINES = 16;
  localparam int IDX_W = $clog2(LINES);

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rmem;
  logic        wmem;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        is_read;
    logic        hit;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mop_t;

  resp_t exp_resp[$];
  mop_t  exp_mop[$];

  // bmem is the memory the responder serves; ref_mem is what the model believes.
  logic [31:0] bmem    [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic        model_valid [LINES];
  int unsigned model_tag   [LINES];

  int completions = 0;
  int acc_cycles  = 0;
  int ack_count   = 0;
  int force_lat   = 0;

  dcache_ctrl #(
    .LINES (LINES),
    .WORDS (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .rmem      (rmem),
    .wmem      (wmem),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] initWord(input logic [29:0] w);
    return {w[15:0] ^ 16'hC3A5, w[15:0]};
  endfunction

  function automatic logic [31:0] memWord(input logic [29:0] w);
    return bmem.exists(w) ? bmem[w] : initWord(w);
  endfunction

  function automatic logic [31:0] refWord(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : initWord(w);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic noteFail(input string name, input string detail);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Monitor: judges every access when the DUT releases stall, and checks quiet outputs otherwise.
  initial begin
    resp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        acc_cycles = 0;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
      end else if (rmem || wmem) begin
        acc_cycles++;
        if (!stall) begin
          if (exp_resp.size() == 0) begin
            noteFail("unexpected_completion", $sformatf("addr=0x%08h completed, expected no access pending", addr));
          end else begin
            e = exp_resp.pop_front();
            if (e.is_read) checkOutput("load_data", rdata, e.data);
            else           checkOutput("store_rdata", rdata, 32'd0);
            checkOutput("done_mem_req", 32'(mem_req), 32'd0);
            checkOutput("pending_mem_ops", 32'(exp_mop.size()), 32'd0);
            if (e.hit) checkOutput("hit_latency", 32'(acc_cycles), 32'd1);
          end
          acc_cycles = 0;
          completions++;
        end else begin
          checkOutput("stall_rdata", rdata, 32'd0);
        end
      end else begin
        checkOutput("idle_stall", 32'(stall), 32'd0);
        checkOutput("idle_rdata", rdata, 32'd0);
      end
    end
  end

  // Backing-memory responder: acks each request after a 1..4 cycle latency.
  initial begin
    int   wait_cnt;
    int   lat;
    mop_t m;
    wait_cnt  = 0;
    lat       = 1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
        checkOutput("req_gap", 32'(mem_req), 32'd0);
      end else if (!reset || !mem_req) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
        wait_cnt++;
        if (wait_cnt >= lat) begin
          if (exp_mop.size() == 0) begin
            noteFail("unexpected_mem_op", $sformatf("we=%0d addr=0x%08h, expected no memory request", mem_we, mem_addr));
          end else begin
            m = exp_mop.pop_front();
            checkOutput("mem_we", 32'(mem_we), 32'(m.we));
            checkOutput("mem_addr", mem_addr, m.addr);
            if (m.we) checkOutput("mem_wdata", mem_wdata, m.wdata);
          end
          if (mem_we) bmem[mem_addr[31:2]] = mem_wdata;
          else        mem_rdata = memWord(mem_addr[31:2]);
          mem_ack = 1'b1;
          ack_count++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic is_write, input logic [31:0] a, input logic [31:0] d, input logic also_read);
    int unsigned idx;
    int unsigned tg;
    resp_t       e;
    mop_t        m;
    int          prev;
    idx       = (a >> 4) % LINES;
    tg        = a >> (4 + IDX_W);
    e.is_read = !is_write;
    e.hit     = 1'b0;
    e.data    = '0;
    if (is_write) begin
      m.we    = 1'b1;
      m.addr  = a & ~32'h3;
      m.wdata = d;
      exp_mop.push_back(m);
      ref_mem[a[31:2]] = d;
    end else begin
      e.hit = model_valid[idx] && (model_tag[idx] == tg);
      if (!e.hit) begin
        for (int k = 0; k < 4; k++) begin
          m.we    = 1'b0;
          m.addr  = (a & ~32'hF) + 32'(4 * k);
          m.wdata = '0;
          exp_mop.push_back(m);
        end
        model_valid[idx] = 1'b1;
        model_tag[idx]   = tg;
      end
      e.data = refWord(a[31:2]);
    end
    exp_resp.push_back(e);
    prev  = completions;
    addr  = a;
    wdata = d;
    wmem  = is_write;
    rmem  = is_write ? also_read : 1'b1;
    for (int c = 0; c < 300 && completions == prev; c++) @(posedge clock);
    if (completions == prev) begin
      noteFail("access_timeout", $sformatf("addr=0x%08h never completed, expected completion within 300 cycles", a));
      exp_resp.delete();
      exp_mop.delete();
    end
    #1;
    rmem  = 1'b0;
    wmem  = 1'b0;
    addr  = $urandom;
    wdata = $urandom;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Starts a refill that must miss, then resets after its second ack.
  task automatic abortRefill(input logic [31:0] a);
    int   base;
    mop_t m;
    base = ack_count;
    for (int k = 0; k < 4; k++) begin
      m.we    = 1'b0;
      m.addr  = (a & ~32'hF) + 32'(4 * k);
      m.wdata = '0;
      exp_mop.push_back(m);
    end
    addr = a;
    rmem = 1'b1;
    for (int c = 0; c < 200 && ack_count < base + 2; c++) begin
      @(posedge clock);
      #2;
    end
    if (ack_count < base + 2) noteFail("abort_timeout", $sformatf("acks=%0d, expected %0d", ack_count - base, 2));
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
    rmem = 1'b0;
    exp_mop.delete();
    exp_resp.delete();
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b0;
    rmem  = 1'b0;
    wmem  = 1'b0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < LINES; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = 0;
    end
    for (int k = 0; k < 4; k++) begin
      bmem[30'h40 + 30'(k)]    = 32'hA0 + 32'(k);
      ref_mem[30'h40 + 30'(k)] = 32'hA0 + 32'(k);
    end
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    $display("[TB] directed sequence");
    applyStimulus(1'b0, 32'h0000_0104, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0108, 32'h0, 1'b0);
    force_lat = 3;
    applyStimulus(1'b1, 32'h0000_010C, 32'hDEAD_BEEF, 1'b0);
    force_lat = 0;
    applyStimulus(1'b0, 32'h0000_010C, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_2000, 32'h1234_5678, 1'b1);
    applyStimulus(1'b0, 32'h0000_2000, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0104, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0504, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0104, 32'h0, 1'b0);
    abortRefill(32'h0000_0C04);
    applyStimulus(1'b0, 32'h0000_0C04, 32'h0, 1'b0);

    $display("[TB] random sequence");
    for (int n = 0; n < 200; n++) begin
      a = 32'($urandom_range(0, 2)) * 32'd256 + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, a, $urandom, 1'($urandom_range(0, 1)));
      else                           applyStimulus(1'b0, a, 32'h0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
